// File: rtl/axis_fork_dup_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_fork_dup_if                                                |
// | Brief    : Stream bundle for the fork: one input stream, two output ones.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface axis_fork_dup_if #(
    parameter int W = 16
);
    logic [W-1:0]      s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [1:0][W-1:0] m_axis_tdata;
    logic [1:0]        m_axis_tvalid;
    logic [1:0]        m_axis_tready;

    // slave: the fork itself (sinks the input stream, sources both outputs)
    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_fork_dup.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_fork_dup                                                   |
// | Brief    : AXI4-Stream broadcast fork, 2-entry register buffer per output. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module axis_fork_dup #(
    parameter int PAR_WDATA_BYTE = 2
) (
    input  wire logic       aclk,
    input  wire logic       areset,
    axis_fork_dup_if.slave  bus
);
    localparam int         W          = 8 * PAR_WDATA_BYTE;
    localparam logic [1:0] c_CNT_EMPTY = 2'd0;
    localparam logic [1:0] c_CNT_ONE   = 2'd1;
    localparam logic [1:0] c_CNT_FULL  = 2'd2;

    logic       ready_q;
    logic       w_push;
    logic [1:0] w_full_next;

    assign w_push            = bus.s_axis_tvalid && ready_q;
    assign bus.s_axis_tready = ready_q;

    // Ready is registered from next-state occupancy, so no m_tready -> s_tready path
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ~|w_full_next;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic [1:0]   cnt_q;
        logic [1:0]   cnt_d;
        logic [W-1:0] head_q;
        logic [W-1:0] head_d;
        logic [W-1:0] skid_q;
        logic [W-1:0] skid_d;
        logic         valid_q;
        logic         w_pop;

        assign w_pop = valid_q && bus.m_axis_tready[g];

        always_comb begin
            cnt_d  = cnt_q;
            head_d = head_q;
            skid_d = skid_q;
            case ({w_push, w_pop})
                2'b10: begin
                    if (cnt_q == c_CNT_EMPTY) begin
                        head_d = bus.s_axis_tdata;
                    end else begin
                        skid_d = bus.s_axis_tdata;
                    end
                    cnt_d = cnt_q + c_CNT_ONE;
                end
                2'b01: begin
                    if (cnt_q == c_CNT_FULL) begin
                        head_d = skid_q;
                    end
                    cnt_d = cnt_q - c_CNT_ONE;
                end
                2'b11: begin
                    // Full-and-push is unreachable while ready gates input; kept ordered anyway
                    if (cnt_q == c_CNT_FULL) begin
                        head_d = skid_q;
                        skid_d = bus.s_axis_tdata;
                    end else begin
                        head_d = bus.s_axis_tdata;
                    end
                end
                default: begin
                end
            endcase
        end

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                cnt_q   <= c_CNT_EMPTY;
                head_q  <= '0;
                skid_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                head_q  <= head_d;
                skid_q  <= skid_d;
                valid_q <= (cnt_d != c_CNT_EMPTY);
            end
        end

        assign w_full_next[g]       = (cnt_d == c_CNT_FULL);
        assign bus.m_axis_tdata[g]  = head_q;
        assign bus.m_axis_tvalid[g] = valid_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_axis_fork_dup.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axis_fork_dup                                                |
// | Brief    : Self-checking bench for axis_fork_dup (vectors + scoreboard).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_axis_fork_dup;
    localparam int W = 16;

    typedef struct {
        logic         sv;
        logic [W-1:0] d;
        logic [1:0]   mr;
        logic         rdy;
        logic [1:0]   mv;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axis_fork_dup_if #(.W(W)) bus ();

    axis_fork_dup #(.PAR_WDATA_BYTE(2)) dut (
        .aclk   (clk),
        .areset (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops [2];
    logic [W-1:0] sbq0 [$];
    logic [W-1:0] sbq1 [$];
    logic         hold_v [2];
    logic [W-1:0] hold_d [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop-compare first (data was pushed at least one edge earlier), then push
    always @(negedge clk) begin
        if (rst) begin
            sbq0.delete();
            sbq1.delete();
            hold_v[0] = 1'b0;
            hold_v[1] = 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (hold_v[n]) begin
                    chk($sformatf("hold_valid_ch%0d", n), {31'd0, bus.m_axis_tvalid[n]}, 32'd1);
                    chk($sformatf("hold_data_ch%0d", n), {16'd0, bus.m_axis_tdata[n]}, {16'd0, hold_d[n]});
                end
                if (bus.m_axis_tvalid[n] && bus.m_axis_tready[n]) begin
                    pops[n]++;
                    if ((n == 0 && sbq0.size() == 0) || (n == 1 && sbq1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_ch%0d: got %0h expected none", n, bus.m_axis_tdata[n]);
                    end else if (n == 0) begin
                        chk("sb_ch0", {16'd0, bus.m_axis_tdata[0]}, {16'd0, sbq0.pop_front()});
                    end else begin
                        chk("sb_ch1", {16'd0, bus.m_axis_tdata[1]}, {16'd0, sbq1.pop_front()});
                    end
                end
                hold_v[n] = bus.m_axis_tvalid[n] && !bus.m_axis_tready[n];
                hold_d[n] = bus.m_axis_tdata[n];
            end
            if (bus.s_axis_tvalid && bus.s_axis_tready) begin
                sbq0.push_back(bus.s_axis_tdata);
                sbq1.push_back(bus.s_axis_tdata);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [13];
        int   p0;
        int   p1;
        int   sent;
        int   budget;
        logic acc;
        logic [W-1:0] cur;

        // Stall sequence: channel 1 blocked, then released
        tv[0]  = '{1'b1, 16'h0100, 2'b01, 1'b1, 2'b00, 16'h0000, 16'h0000};
        tv[1]  = '{1'b1, 16'h0101, 2'b01, 1'b1, 2'b11, 16'h0100, 16'h0100};
        tv[2]  = '{1'b1, 16'h0102, 2'b01, 1'b0, 2'b11, 16'h0101, 16'h0100};
        tv[3]  = '{1'b1, 16'h0102, 2'b01, 1'b0, 2'b10, 16'h0000, 16'h0100};
        tv[4]  = '{1'b1, 16'h0102, 2'b11, 1'b0, 2'b10, 16'h0000, 16'h0100};
        tv[5]  = '{1'b1, 16'h0102, 2'b11, 1'b1, 2'b10, 16'h0000, 16'h0101};
        tv[6]  = '{1'b0, 16'h0000, 2'b11, 1'b1, 2'b11, 16'h0102, 16'h0102};
        tv[7]  = '{1'b0, 16'h0000, 2'b11, 1'b1, 2'b00, 16'h0000, 16'h0000};
        // Simultaneous push and pop at occupancy 1
        tv[8]  = '{1'b1, 16'h1111, 2'b00, 1'b1, 2'b00, 16'h0000, 16'h0000};
        tv[9]  = '{1'b1, 16'h1234, 2'b11, 1'b1, 2'b11, 16'h1111, 16'h1111};
        tv[10] = '{1'b0, 16'h0000, 2'b00, 1'b1, 2'b11, 16'h1234, 16'h1234};
        tv[11] = '{1'b0, 16'h0000, 2'b11, 1'b1, 2'b11, 16'h1234, 16'h1234};
        tv[12] = '{1'b0, 16'h0000, 2'b11, 1'b1, 2'b00, 16'h0000, 16'h0000};

        pops[0] = 0;
        pops[1] = 0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 16'hAAAA;
        bus.m_axis_tready = 2'b11;

        // Reset held with valid input offered
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mvalid", {30'd0, bus.m_axis_tvalid}, 32'd0);
            chk("rst_sready", {31'd0, bus.s_axis_tready}, 32'd0);
            chk("rst_data0", {16'd0, bus.m_axis_tdata[0]}, 32'd0);
            chk("rst_data1", {16'd0, bus.m_axis_tdata[1]}, 32'd0);
        end
        tick();
        rst = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("rel_sready_pre", {31'd0, bus.s_axis_tready}, 32'd0);
        tick();
        @(negedge clk);
        chk("rel_sready", {31'd0, bus.s_axis_tready}, 32'd1);
        chk("rel_mvalid", {30'd0, bus.m_axis_tvalid}, 32'd0);
        tick();
        @(negedge clk);
        chk("rel_mvalid2", {30'd0, bus.m_axis_tvalid}, 32'd0);
        tick();

        // Back-to-back streaming
        p0 = pops[0];
        p1 = pops[1];
        for (int i = 1; i <= 16; i++) begin
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = W'(i);
            @(negedge clk);
            chk("stream_sready", {31'd0, bus.s_axis_tready}, 32'd1);
            if (i > 1) begin
                chk("stream_mvalid", {30'd0, bus.m_axis_tvalid}, 32'd3);
                chk("stream_d0", {16'd0, bus.m_axis_tdata[0]}, 32'(i - 1));
                chk("stream_d1", {16'd0, bus.m_axis_tdata[1]}, 32'(i - 1));
            end
            tick();
        end
        bus.s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("stream_last_d0", {16'd0, bus.m_axis_tdata[0]}, 32'd16);
        chk("stream_last_d1", {16'd0, bus.m_axis_tdata[1]}, 32'd16);
        tick();
        chk("stream_count0", 32'(pops[0] - p0), 32'd16);
        chk("stream_count1", 32'(pops[1] - p1), 32'd16);

        // Vector table: stall and simultaneous push/pop
        for (int i = 0; i < 13; i++) begin
            bus.s_axis_tvalid = tv[i].sv;
            bus.s_axis_tdata  = tv[i].d;
            bus.m_axis_tready = tv[i].mr;
            @(negedge clk);
            chk($sformatf("vec%0d_sready", i), {31'd0, bus.s_axis_tready}, {31'd0, tv[i].rdy});
            chk($sformatf("vec%0d_mvalid", i), {30'd0, bus.m_axis_tvalid}, {30'd0, tv[i].mv});
            if (tv[i].mv[0])
                chk($sformatf("vec%0d_d0", i), {16'd0, bus.m_axis_tdata[0]}, {16'd0, tv[i].d0});
            if (tv[i].mv[1])
                chk($sformatf("vec%0d_d1", i), {16'd0, bus.m_axis_tdata[1]}, {16'd0, tv[i].d1});
            tick();
        end

        // Random valid and independent random backpressure
        sent   = 0;
        budget = 0;
        cur    = '0;
        bus.s_axis_tvalid = 1'b0;
        while (sent < 1000 && budget < 20000) begin
            if (!bus.s_axis_tvalid && ($urandom_range(1) == 1)) begin
                bus.s_axis_tvalid = 1'b1;
                bus.s_axis_tdata  = cur;
            end
            bus.m_axis_tready = 2'($urandom_range(3));
            @(negedge clk);
            acc = bus.s_axis_tvalid && bus.s_axis_tready;
            tick();
            if (acc) begin
                sent++;
                cur++;
                bus.s_axis_tvalid = 1'b0;
            end
            budget++;
        end
        chk("rand_sent", 32'(sent), 32'd1000);
        bus.s_axis_tvalid = 1'b0;
        bus.m_axis_tready = 2'b11;
        for (int i = 0; i < 20 && (sbq0.size() != 0 || sbq1.size() != 0); i++) tick();
        chk("rand_drain0", 32'(sbq0.size()), 32'd0);
        chk("rand_drain1", 32'(sbq1.size()), 32'd0);

        // Fill both buffers, then reset mid-cycle
        bus.m_axis_tready = 2'b00;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 16'h7001;
        tick();
        bus.s_axis_tdata  = 16'h7002;
        tick();
        bus.s_axis_tdata  = 16'h7003;
        @(negedge clk);
        chk("full_sready", {31'd0, bus.s_axis_tready}, 32'd0);
        chk("full_mvalid", {30'd0, bus.m_axis_tvalid}, 32'd3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_mvalid", {30'd0, bus.m_axis_tvalid}, 32'd0);
        chk("mid_rst_sready", {31'd0, bus.s_axis_tready}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        bus.s_axis_tdata  = 16'h5555;
        bus.m_axis_tready = 2'b11;
        tick();
        @(negedge clk);
        chk("post_rst_sready", {31'd0, bus.s_axis_tready}, 32'd1);
        chk("post_rst_mvalid", {30'd0, bus.m_axis_tvalid}, 32'd0);
        tick();
        bus.s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_v", {30'd0, bus.m_axis_tvalid}, 32'd3);
        chk("post_rst_d0", {16'd0, bus.m_axis_tdata[0]}, 32'h5555);
        chk("post_rst_d1", {16'd0, bus.m_axis_tdata[1]}, 32'h5555);
        tick();
        tick();
        chk("end_q0", 32'(sbq0.size()), 32'd0);
        chk("end_q1", 32'(sbq1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
